rr_mux: RTL and testbench

RR_MUX -- requirements
Module: rr_mux

---
 rtl/rr_mux.sv | 91 +++++++++
 tb/tb_rr_mux.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux.sv
// Round-robin / fixed-priority N-to-1 arbiter with a single registered output stage.
// Each beat carries the source channel index so downstream logic can route responses.
module rr_mux #(
    parameter int N  = 32,
    parameter int CH = 4,
    parameter int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic            mode,
    output logic [N-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_sel
);

    // Handshake: a beat moves on any port when its valid and ready are both high
    // at a rising edge; valid never waits on ready, and ready never looks at data.

    logic [SW-1:0] ptr;
    logic [SW-1:0] grant;
    logic [SW-1:0] ptr_nxt;
    logic [SW:0]   idx;
    logic          found;
    logic          load_en;
    logic          in_fire;
    logic [N-1:0]  sel_data;

    assign load_en = !out_valid || out_ready;

    // Search CH candidates; in round-robin the start rotates from ptr with wrap mod CH.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int j = 0; j < CH; j++) begin
            if (mode) begin
                idx = (SW+1)'(j);
            end else begin
                idx = {1'b0, ptr} + (SW+1)'(j);
                if (idx >= (SW+1)'(CH)) begin
                    idx = idx - (SW+1)'(CH);
                end
            end
            if (!found && in_valid[idx[SW-1:0]]) begin
                found = 1'b1;
                grant = idx[SW-1:0];
            end
        end
    end

    // rst_n gating keeps in_ready low during reset, when out_valid is forced low.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CH; i++) begin
            in_ready[i] = rst_n && load_en && (grant == SW'(i)) && in_valid[i];
        end
    end

    assign in_fire = |in_ready;
    assign ptr_nxt = (grant == SW'(CH - 1)) ? '0 : grant + SW'(1);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (grant == SW'(i)) begin
                sel_data = in_data[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (in_fire) begin
            out_data  <= sel_data;
            out_sel   <= grant;
            out_valid <= 1'b1;
            ptr       <= ptr_nxt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux (CH=4, N=32): reset, round-robin, fixed priority,
// backpressure, sparse wrap and asynchronous reset during a stall.
module tb_rr_mux;

    localparam int N  = 32;
    localparam int CH = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic            mode;
    logic [N-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_sel;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] chd [CH];

    rr_mux #(.N(N), .CH(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'hf;
        out_ready = 1'b1;
        mode      = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 2'd0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b sel=%0d data=%h, want v=0 sel=0 data=0", out_valid, out_sel, out_data);
        end
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, want 0000", in_ready);
        end
        in_valid = 4'h0;
        rst_n    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if ({out_valid, out_sel, out_data, in_ready} !== {1'b0, 2'd0, 32'h0, 4'b0000}) begin
                n_fail++;
                $display("FAIL idle_c%0d: got v=%b sel=%0d data=%h rdy=%b, want all zero", c, out_valid, out_sel, out_data, in_ready);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [SW-1:0] exp_sel [5];
        logic [CH-1:0] exp_rdy [5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        mode     = 1'b0;
        in_valid = 4'hf;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (in_ready !== exp_rdy[c]) begin
                n_fail++;
                $display("FAIL rr_ready_c%0d: got %b, want %b", c, in_ready, exp_rdy[c]);
            end
            tick();
            n_checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, exp_sel[c], chd[exp_sel[c]]}) begin
                n_fail++;
                $display("FAIL rr_beat_c%0d: got v=%b sel=%0d data=%h, want v=1 sel=%0d data=%h", c, out_valid, out_sel, out_data, exp_sel[c], chd[exp_sel[c]]);
            end
        end
        in_valid = 4'h0;
        tick();
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 2'd0, 32'h89abcdef}) begin
            n_fail++;
            $display("FAIL rr_drain: got v=%b sel=%0d data=%h, want v=0 sel=0 data=89abcdef", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_fixed_priority();
        mode     = 1'b1;
        in_valid = 4'hf;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0001) begin
                n_fail++;
                $display("FAIL fp_ready_c%0d: got %b, want 0001", c, in_ready);
            end
            tick();
            n_checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 32'h89abcdef}) begin
                n_fail++;
                $display("FAIL fp_beat_c%0d: got v=%b sel=%0d data=%h, want v=1 sel=0 data=89abcdef", c, out_valid, out_sel, out_data);
            end
        end
        in_valid = 4'h0;
        mode     = 1'b0;
        tick();
    endtask

    // Pointer is 1 on entry, so a lone ch2 request is granted first.
    task automatic test_backpressure();
        in_valid = 4'b0100;
        tick();
        out_ready = 1'b0;
        in_valid  = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_ready_c%0d: got %b, want 0000", c, in_ready);
            end
            tick();
            n_checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, 2'd2, 32'hcafebabe}) begin
                n_fail++;
                $display("FAIL bp_hold_c%0d: got v=%b sel=%0d data=%h, want v=1 sel=2 data=cafebabe", c, out_valid, out_sel, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b, want 1000", in_ready);
        end
        tick();
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd3, 32'hdeadbeef}) begin
            n_fail++;
            $display("FAIL bp_next: got v=%b sel=%0d data=%h, want v=1 sel=3 data=deadbeef", out_valid, out_sel, out_data);
        end
        in_valid = 4'h0;
        tick();
    endtask

    // Pointer is 0 on entry; a ch1 beat moves it to 2.
    task automatic test_sparse_wrap();
        in_valid = 4'b0010;
        tick();
        in_valid = 4'b1010;
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL sw_first_ready: got %b, want 1000", in_ready);
        end
        tick();
        n_checks++;
        if ({out_sel, out_data} !== {2'd3, 32'hdeadbeef}) begin
            n_fail++;
            $display("FAIL sw_first: got sel=%0d data=%h, want sel=3 data=deadbeef", out_sel, out_data);
        end
        tick();
        n_checks++;
        if ({out_sel, out_data} !== {2'd1, 32'hc0be5417}) begin
            n_fail++;
            $display("FAIL sw_second: got sel=%0d data=%h, want sel=1 data=c0be5417", out_sel, out_data);
        end
        in_valid = 4'b0000;
        tick();
        in_valid = 4'hf;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL sw_ptr: got in_ready %b, want 0100 (ptr=2)", in_ready);
        end
        in_valid = 4'h0;
        tick();
    endtask

    // Pointer is 2 on entry; ch0 beat leaves it at 1, reset must bring it back to 0.
    task automatic test_async_reset();
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        tick();
        in_valid = 4'b0000;
        tick();
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 32'h89abcdef}) begin
            n_fail++;
            $display("FAIL ar_stall: got v=%b sel=%0d data=%h, want v=1 sel=0 data=89abcdef", out_valid, out_sel, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 2'd0, 32'h0}) begin
            n_fail++;
            $display("FAIL ar_immediate: got v=%b sel=%0d data=%h, want v=0 sel=0 data=0", out_valid, out_sel, out_data);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'hf;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL ar_restart_ready: got %b, want 0001", in_ready);
        end
        tick();
        n_checks++;
        if ({out_valid, out_sel} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL ar_restart0: got v=%b sel=%0d, want v=1 sel=0", out_valid, out_sel);
        end
        tick();
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd1, 32'hc0be5417}) begin
            n_fail++;
            $display("FAIL ar_restart1: got v=%b sel=%0d data=%h, want v=1 sel=1 data=c0be5417", out_valid, out_sel, out_data);
        end
        in_valid = 4'h0;
        tick();
    endtask

    initial begin
        chd     = '{32'h89abcdef, 32'hc0be5417, 32'hcafebabe, 32'hdeadbeef};
        in_data = {chd[3], chd[2], chd[1], chd[0]};
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_sparse_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
